// File: rtl/basic_computer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : basic_computer_pkg
//  Description : Shared constants for the basic computer. Holds the
//                common-bus source select codes and the state encoding of
//                the instruction-cycle sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package basic_computer_pkg;

    // Common-bus source select codes
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // Instruction-cycle sequencer states
    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_EXEC = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/threebitdecoder.sv
`default_nettype none
// ============================================================================
//  Module      : threebitdecoder
//  Description : 3-to-8 one-hot decoder (opcode -> instruction line D0..D7).
//  Ports       : i_code   [2:0]  binary code
//                o_onehot [7:0]  one-hot decode, bit i set when i_code == i
//  Revision    : 1.0  initial release
// ============================================================================
module threebitdecoder (
    input  logic [2:0] i_code,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'h01 << i_code;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_cycle_sequencer
//  Description : Instruction-cycle controller for the basic computer. Steps
//                fetch (T0/T1), decode (T2) and indirect (T3) phases, drives
//                bus select and register load strobes, registers the one-hot
//                opcode decode and hands each instruction to the execute logic
//                through an exec_start/exec_done handshake with a timeout.
//  Ports       : clk, reset_n          clock, async active-low reset
//                start                 leave HALT
//                ir_opcode, ir_indirect IR fields, valid at T2
//                mem_ready             memory read data valid this cycle
//                exec_done, halt       execute handshake / HLT executed
//                bus_sel, ar_ld, ir_ld, pc_inc, mem_rd   datapath strobes
//                t_state, d_op         one-hot timing and decode
//                exec_start, running, timeout_err        status
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_cycle_sequencer
    import basic_computer_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] ir_opcode,
    input  logic       ir_indirect,
    input  logic       mem_ready,
    input  logic       exec_done,
    input  logic       halt,
    output logic [2:0] bus_sel,
    output logic       ar_ld,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       mem_rd,
    output logic [7:0] t_state,
    output logic [7:0] d_op,
    output logic       exec_start,
    output logic       running,
    output logic       timeout_err
);

    // Last value of the completed-EXEC-cycle counter before timing out
    localparam logic [7:0] c_cnt_last = 8'(EXEC_TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sc, w_sc_nxt;
    logic       r_first, w_first_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       r_ind;
    logic [7:0] r_d_op;
    logic       w_dec_ld;
    logic [7:0] w_dec;

    threebitdecoder u_dec (
        .i_code   (ir_opcode),
        .o_onehot (w_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_HALT;
            r_sc      <= 3'd0;
            r_first   <= 1'b0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
            r_ind     <= 1'b0;
            r_d_op    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_sc      <= w_sc_nxt;
            r_first   <= w_first_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_dec_ld) begin
                r_d_op <= w_dec;
                r_ind  <= ir_indirect;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sc_nxt      = r_sc;
        w_first_nxt   = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        w_dec_ld      = 1'b0;
        bus_sel       = BUS_NONE;
        ar_ld         = 1'b0;
        ir_ld         = 1'b0;
        pc_inc        = 1'b0;
        mem_rd        = 1'b0;
        exec_start    = 1'b0;

        case (r_state)
            ST_HALT: begin
                if (start && !r_timeout) begin
                    w_state_nxt = ST_T0;
                    w_sc_nxt    = 3'd0;
                end
            end
            ST_T0: begin
                bus_sel     = BUS_PC;
                ar_ld       = 1'b1;
                w_state_nxt = ST_T1;
                w_sc_nxt    = 3'd1;
            end
            ST_T1: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                if (mem_ready) begin
                    ir_ld       = 1'b1;
                    pc_inc      = 1'b1;
                    w_state_nxt = ST_T2;
                    w_sc_nxt    = 3'd2;
                end
            end
            ST_T2: begin
                bus_sel  = BUS_IR;
                ar_ld    = 1'b1;
                w_dec_ld = 1'b1;
                w_sc_nxt = 3'd3;
                // Opcode 7 (register/IO) has no operand fetch phase
                if (ir_opcode == 3'd7) begin
                    w_state_nxt = ST_EXEC;
                    w_first_nxt = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_T3;
                end
            end
            ST_T3: begin
                if (r_ind) begin
                    mem_rd  = 1'b1;
                    bus_sel = BUS_MEM;
                    if (mem_ready) begin
                        ar_ld       = 1'b1;
                        w_state_nxt = ST_EXEC;
                        w_sc_nxt    = 3'd4;
                        w_first_nxt = 1'b1;
                        w_cnt_nxt   = 8'd0;
                    end
                end else begin
                    w_state_nxt = ST_EXEC;
                    w_sc_nxt    = 3'd4;
                    w_first_nxt = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_EXEC: begin
                exec_start = r_first;
                w_sc_nxt   = (r_sc == 3'd7) ? 3'd7 : r_sc + 3'd1;
                // exec_done takes priority over a timeout in the same cycle
                if (exec_done) begin
                    w_state_nxt = halt ? ST_HALT : ST_T0;
                    w_sc_nxt    = 3'd0;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HALT;
                    w_sc_nxt      = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
                w_sc_nxt    = 3'd0;
            end
        endcase
    end

    assign t_state     = (r_state == ST_HALT) ? 8'h00 : (8'h01 << r_sc);
    assign running     = (r_state != ST_HALT);
    assign d_op        = r_d_op;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_instruction_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_cycle_sequencer
//  Description : Self-checking bench for instruction_cycle_sequencer. Each
//                instruction is described by its opcode, indirect bit, memory
//                stall counts and EXEC length; the expected per-cycle outputs
//                are derived from that description.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_cycle_sequencer;

    localparam int         EXEC_TO = 15;
    localparam logic [2:0] B_NONE  = 3'd0;
    localparam logic [2:0] B_PC    = 3'd2;
    localparam logic [2:0] B_IR    = 3'd5;
    localparam logic [2:0] B_MEM   = 3'd7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] ir_opcode;
    logic       ir_indirect;
    logic       mem_ready;
    logic       exec_done;
    logic       halt;
    logic [2:0] bus_sel;
    logic       ar_ld;
    logic       ir_ld;
    logic       pc_inc;
    logic       mem_rd;
    logic [7:0] t_state;
    logic [7:0] d_op;
    logic       exec_start;
    logic       running;
    logic       timeout_err;

    int   n_tests;
    int   n_fail;
    logic exp_to;

    instruction_cycle_sequencer #(.EXEC_TIMEOUT(EXEC_TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ir_opcode   (ir_opcode),
        .ir_indirect (ir_indirect),
        .mem_ready   (mem_ready),
        .exec_done   (exec_done),
        .halt        (halt),
        .bus_sel     (bus_sel),
        .ar_ld       (ar_ld),
        .ir_ld       (ir_ld),
        .pc_inc      (pc_inc),
        .mem_rd      (mem_rd),
        .t_state     (t_state),
        .d_op        (d_op),
        .exec_start  (exec_start),
        .running     (running),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs (just after posedge), check at negedge.
    task automatic step(input logic st, input logic mr, input logic ed, input logic hl,
                        input logic [2:0] eb, input logic ear, input logic eir,
                        input logic epc, input logic erd, input logic [7:0] ets,
                        input logic ees, input logic erun);
        start     = st;
        mem_ready = mr;
        exec_done = ed;
        halt      = hl;
        @(negedge clk);
        chk("bus_sel", 32'(bus_sel), 32'(eb));
        chk("ar_ld", 32'(ar_ld), 32'(ear));
        chk("ir_ld", 32'(ir_ld), 32'(eir));
        chk("pc_inc", 32'(pc_inc), 32'(epc));
        chk("mem_rd", 32'(mem_rd), 32'(erd));
        chk("t_state", 32'(t_state), 32'(ets));
        chk("exec_start", 32'(exec_start), 32'(ees));
        chk("running", 32'(running), 32'(erun));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        step(st, rb(), 1'b0, rb(), B_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Runs one instruction starting in T0. st1/st3: mem_ready-low cycles in
    // T1/T3; ex_len: EXEC cycles up to and including exec_done; tmo: never
    // assert exec_done and expect a timeout.
    task automatic do_instr(input logic [2:0] op, input logic ind, input int st1,
                            input int st3, input int ex_len, input logic hlt,
                            input logic tmo);
        int         base;
        int         n;
        int         sc_i;
        logic       ed;
        logic [7:0] exp_d;
        ir_opcode   = op;
        ir_indirect = ind;
        step(rb(), rb(), 1'b0, 1'b0, B_PC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        for (int k = 0; k < st1; k++)
            step(rb(), 1'b0, 1'b0, 1'b0, B_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        step(rb(), 1'b1, 1'b0, 1'b0, B_MEM, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1);
        step(rb(), rb(), 1'b0, 1'b0, B_IR, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1);
        if (op != 3'd7) begin
            if (ind) begin
                for (int k = 0; k < st3; k++)
                    step(rb(), 1'b0, 1'b0, 1'b0, B_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
                step(rb(), 1'b1, 1'b0, 1'b0, B_MEM, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
            end else begin
                step(rb(), rb(), 1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1);
            end
            base = 4;
        end else begin
            base = 3;
        end
        exp_d = 8'h01 << op;
        chk("d_op", 32'(d_op), 32'(exp_d));
        n = tmo ? EXEC_TO : ex_len;
        for (int k = 0; k < n; k++) begin
            ed   = (k == n - 1) && !tmo;
            sc_i = (base + k > 7) ? 7 : base + k;
            step(rb(), rb(), ed, ed ? hlt : rb(), B_NONE, 1'b0, 1'b0, 1'b0, 1'b0,
                 8'h01 << sc_i, (k == 0), 1'b1);
        end
        if (tmo)
            exp_to = 1'b1;
    endtask

    initial begin
        logic [2:0] rop;
        logic       rind;
        n_tests     = 0;
        n_fail      = 0;
        exp_to      = 1'b0;
        reset_n     = 1'b0;
        start       = 1'b0;
        ir_opcode   = 3'd0;
        ir_indirect = 1'b0;
        mem_ready   = 1'b0;
        exec_done   = 1'b0;
        halt        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst bus_sel", 32'(bus_sel), 32'(B_NONE));
        chk("rst t_state", 32'(t_state), 32'h0);
        chk("rst d_op", 32'(d_op), 32'h0);
        chk("rst running", 32'(running), 32'h0);
        chk("rst exec_start", 32'(exec_start), 32'h0);
        chk("rst timeout_err", 32'(timeout_err), 32'h0);
        chk("rst strobes", 32'({ar_ld, ir_ld, pc_inc, mem_rd}), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // HALT holds without start, then start -> T0
        idle(1'b0);
        idle(1'b1);
        do_instr(3'b010, 1'b0, 0, 0, 2, 1'b0, 1'b0);
        do_instr(3'b001, 1'b1, 0, 3, 1, 1'b0, 1'b0);
        do_instr(3'b111, rb(), 0, 0, 1, 1'b0, 1'b0);
        do_instr(3'b100, 1'b0, 2, 0, 1, 1'b0, 1'b0);
        // exec_done on the last allowed cycle beats the timeout
        do_instr(3'b011, 1'b0, 0, 0, EXEC_TO, 1'b0, 1'b0);
        // HLT
        do_instr(3'b110, 1'b1, 1, 1, 3, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Random instruction mix
        for (int i = 0; i < 10; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rind = rb();
            do_instr(rop, rind, $urandom_range(0, 2), $urandom_range(0, 3),
                     $urandom_range(1, 4), 1'b0, 1'b0);
        end

        // Timeout: sticky, start ignored
        do_instr(3'b101, 1'b0, 0, 0, 1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Reset clears timeout_err
        reset_n = 1'b0;
        #1;
        exp_to = 1'b0;
        chk("rst clears timeout_err", 32'(timeout_err), 32'h0);
        chk("rst running", 32'(running), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset aborts an instruction in T1
        idle(1'b1);
        ir_opcode   = 3'd4;
        ir_indirect = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, B_PC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        mem_ready = 1'b0;
        #1;
        chk("T1 mem_rd", 32'(mem_rd), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort mem_rd", 32'(mem_rd), 32'h0);
        chk("abort t_state", 32'(t_state), 32'h0);
        chk("abort running", 32'(running), 32'h0);
        chk("abort bus_sel", 32'(bus_sel), 32'(B_NONE));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0);
        idle(1'b1);
        do_instr(3'b000, 1'b1, 1, 2, 2, 1'b1, 1'b0);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
